// File: rtl/alu_cmd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cmd_engine : framed byte-stream command engine (echo / add32 / mul32)  |
// | Optional mul32 opcode enabled by defining ALU_MUL_EN.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_cmd_engine (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i
);

  localparam logic [2:0] c_HDR_OP   = 3'd0;
  localparam logic [2:0] c_HDR_RSV  = 3'd1;
  localparam logic [2:0] c_HDR_LEN0 = 3'd2;
  localparam logic [2:0] c_HDR_LEN1 = 3'd3;
  localparam logic [2:0] c_ECHO     = 3'd4;
  localparam logic [2:0] c_OPND     = 3'd5;
  localparam logic [2:0] c_DRAIN    = 3'd6;
  localparam logic [2:0] c_RESULT   = 3'd7;

  localparam logic [7:0] c_OP_ECHO  = 8'hEC;
  localparam logic [7:0] c_OP_ADD   = 8'hAD;

  logic [2:0]  r_state;
  logic [7:0]  r_op;
  logic [7:0]  r_len_lo;
  logic [15:0] r_rem;
  logic [31:0] r_word;
  logic [31:0] r_acc;
  logic [1:0]  r_byte_idx;
  logic [1:0]  r_out_cnt;
  logic        r_word_valid;
  logic        r_have_acc;
  logic [7:0]  r_m_data;
  logic        r_m_valid;

  logic        w_s_ready;
  logic        w_s_hs;
  logic        w_is_arith;
  logic        w_last_byte;
  logic [15:0] w_len;
  logic [15:0] w_rem;
  logic [31:0] w_word_next;
  logic [31:0] w_combined;
  logic [31:0] w_acc_next;
  logic [7:0]  w_res_byte;

`ifdef ALU_MUL_EN
  localparam logic [7:0] c_OP_MUL = 8'h88;
  assign w_is_arith = (r_op == c_OP_ADD) || (r_op == c_OP_MUL);
  assign w_combined = (r_op == c_OP_MUL) ? (r_acc * r_word) : (r_acc + r_word);
`else
  assign w_is_arith = (r_op == c_OP_ADD);
  assign w_combined = r_acc + r_word;
`endif

  // Header opcode waits for any echo byte still in the output register.
  always_comb begin
    w_s_ready = 1'b0;
    case (r_state)
      c_HDR_OP:   w_s_ready = !r_m_valid;
      c_ECHO:     w_s_ready = !r_m_valid || m_ready_i;
      c_RESULT:   w_s_ready = 1'b0;
      default:    w_s_ready = 1'b1;
    endcase
  end

  assign s_ready_o   = rst_ni && w_s_ready;
  assign w_s_hs      = s_valid_i && s_ready_o;
  assign w_last_byte = (r_rem == 16'd1);
  assign w_len       = {s_data_i, r_len_lo};
  assign w_rem       = (w_len < 16'd4) ? 16'd0 : (w_len - 16'd4);
  assign w_acc_next  = r_word_valid ? (r_have_acc ? w_combined : r_word) : r_acc;
  assign m_data_o    = r_m_data;
  assign m_valid_o   = r_m_valid;

  // A new word starts from zero so a short final word is zero-extended.
  always_comb begin
    w_word_next = (r_byte_idx == 2'd0) ? 32'd0 : r_word;
    case (r_byte_idx)
      2'd0:    w_word_next[7:0]   = s_data_i;
      2'd1:    w_word_next[15:8]  = s_data_i;
      2'd2:    w_word_next[23:16] = s_data_i;
      default: w_word_next[31:24] = s_data_i;
    endcase
  end

  always_comb begin
    w_res_byte = r_acc[31:24];
    case (r_out_cnt)
      2'd0:    w_res_byte = r_acc[15:8];
      2'd1:    w_res_byte = r_acc[23:16];
      default: w_res_byte = r_acc[31:24];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= c_HDR_OP;
      r_op         <= 8'h00;
      r_len_lo     <= 8'h00;
      r_rem        <= 16'd0;
      r_word       <= 32'd0;
      r_acc        <= 32'd0;
      r_byte_idx   <= 2'd0;
      r_out_cnt    <= 2'd0;
      r_word_valid <= 1'b0;
      r_have_acc   <= 1'b0;
      r_m_data     <= 8'h00;
      r_m_valid    <= 1'b0;
    end else begin
      if (r_word_valid) begin
        r_acc        <= w_acc_next;
        r_have_acc   <= 1'b1;
        r_word_valid <= 1'b0;
      end
      if (r_m_valid && m_ready_i && (r_state != c_RESULT)) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        c_HDR_OP: begin
          if (w_s_hs) begin
            r_op       <= s_data_i;
            r_acc      <= 32'd0;
            r_have_acc <= 1'b0;
            r_byte_idx <= 2'd0;
            r_state    <= c_HDR_RSV;
          end
        end
        c_HDR_RSV: begin
          if (w_s_hs) r_state <= c_HDR_LEN0;
        end
        c_HDR_LEN0: begin
          if (w_s_hs) begin
            r_len_lo <= s_data_i;
            r_state  <= c_HDR_LEN1;
          end
        end
        c_HDR_LEN1: begin
          if (w_s_hs) begin
            r_rem <= w_rem;
            if (w_rem != 16'd0) begin
              if (r_op == c_OP_ECHO)  r_state <= c_ECHO;
              else if (w_is_arith)    r_state <= c_OPND;
              else                    r_state <= c_DRAIN;
            end else if (w_is_arith) begin
              // No operands: the zero accumulator goes out immediately.
              r_m_data  <= 8'h00;
              r_m_valid <= 1'b1;
              r_out_cnt <= 2'd0;
              r_state   <= c_RESULT;
            end else begin
              r_state <= c_HDR_OP;
            end
          end
        end
        c_ECHO: begin
          if (w_s_hs) begin
            r_m_data  <= s_data_i;
            r_m_valid <= 1'b1;
            r_rem     <= r_rem - 16'd1;
            if (w_last_byte) r_state <= c_HDR_OP;
          end
        end
        c_OPND: begin
          if (w_s_hs) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            r_rem      <= r_rem - 16'd1;
            if ((r_byte_idx == 2'd3) || w_last_byte) r_word_valid <= 1'b1;
            if (w_last_byte) begin
              r_out_cnt <= 2'd0;
              r_state   <= c_RESULT;
            end
          end
        end
        c_DRAIN: begin
          if (w_s_hs) begin
            r_rem <= r_rem - 16'd1;
            if (w_last_byte) r_state <= c_HDR_OP;
          end
        end
        default: begin
          // RESULT: first cycle folds in the final word and loads byte 0.
          if (!r_m_valid) begin
            r_m_data  <= w_acc_next[7:0];
            r_m_valid <= 1'b1;
            r_out_cnt <= 2'd0;
          end else if (m_ready_i) begin
            if (r_out_cnt == 2'd3) begin
              r_m_valid <= 1'b0;
              r_state   <= c_HDR_OP;
            end else begin
              r_m_data  <= w_res_byte;
              r_out_cnt <= r_out_cnt + 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_cmd_engine : randomized and directed bench for alu_cmd_engine       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_engine;

  typedef logic [7:0] bq_t[$];

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] s_data_i = 8'h00;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b1;

  int vectors = 0;
  int errors  = 0;
  int rdy_mode = 0;
  bq_t got_q;
  bq_t exp_q;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  alu_cmd_engine dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Transmitter side: 0 always ready, 1 toggling, 2 random, 3 never ready.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = ~m_ready_i;
        2:       m_ready_i = 1'($urandom_range(0, 1));
        default: m_ready_i = 1'b0;
      endcase
    end
  end

  // Output monitor: collects handshaken bytes and checks hold-while-stalled.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (m_valid_o && m_ready_i) got_q.push_back(m_data_o);
      if (prev_stall) begin
        vectors++;
        if (m_valid_o !== 1'b1 || m_data_o !== prev_data) begin
          errors++;
          $display("FAIL hold_while_stalled: valid=%b data=%02h, required valid=1 data=%02h",
                   m_valid_o, m_data_o, prev_data);
        end
      end
    end
    prev_stall = rst_ni && m_valid_o && !m_ready_i;
    prev_data  = m_data_o;
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_data_i  = b;
    s_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (s_ready_o) break;
      t++;
      if (t > 2000) begin
        vectors++;
        errors++;
        $display("FAIL input_timeout: byte %02h not accepted, required acceptance", b);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input bq_t p, input bit gaps);
    foreach (p[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk_i);
        #1;
      end
      send_byte(p[i]);
    end
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_q.size() < n && t < 5000) begin
      @(posedge clk_i);
      t++;
    end
    repeat (12) @(posedge clk_i);
    #1;
  endtask

  // Reference: parse one packet and append its response bytes.
  task automatic model_append(input bq_t p);
    int len, rem, nops;
    logic [31:0] acc, w;
    len = int'({p[3], p[2]});
    rem = (len < 4) ? 0 : len - 4;
    if (p[0] == 8'hEC) begin
      for (int i = 0; i < rem; i++) exp_q.push_back(p[4 + i]);
    end else if (p[0] == 8'hAD || (MUL_EN && p[0] == 8'h88)) begin
      nops = (rem + 3) / 4;
      acc  = 32'd0;
      for (int k = 0; k < nops; k++) begin
        w = 32'd0;
        for (int j = 0; j < 4; j++)
          if (4 * k + j < rem) w = w + (32'(p[4 + 4 * k + j]) << (8 * j));
        if (k == 0)              acc = w;
        else if (p[0] == 8'hAD)  acc = acc + w;
        else                     acc = acc * w;
      end
      for (int j = 0; j < 4; j++) exp_q.push_back(acc[8 * j +: 8]);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (s_ready_o !== 1'b0 || m_valid_o !== 1'b0 || m_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b m_data=%02h, required 0 0 00",
               s_ready_o, m_valid_o, m_data_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: s_ready=%b, required 1", s_ready_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_add();
    bq_t p;
    got_q.delete(); exp_q.delete();
    rdy_mode = 0;
    p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(p, 1'b0);
    // Result must not be valid in the cycle right after the last byte, then valid.
    @(negedge clk_i);
    vectors++;
    if (m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL add_latency_early: m_valid=%b, required 0", m_valid_o);
    end
    @(negedge clk_i);
    vectors++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'h03) begin
      errors++;
      $display("FAIL add_latency: m_valid=%b m_data=%02h, required 1 03", m_valid_o, m_data_o);
    end
    exp_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00};
    p = '{8'hAD, 8'h00, 8'h0A, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00};
    send_pkt(p, 1'b1);
    p = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
    send_pkt(p, 1'b0);
    wait_out(exp_q.size());
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL add_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL add_byte[%0d]: got %02h, required %02h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_echo_backpressure();
    bq_t p;
    got_q.delete();
    rdy_mode = 0;
    p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41};
    send_pkt(p, 1'b0);
    @(negedge clk_i);
    vectors++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'h41) begin
      errors++;
      $display("FAIL echo_latency: m_valid=%b m_data=%02h, required 1 41", m_valid_o, m_data_o);
    end
    rdy_mode = 1;
    @(posedge clk_i);
    #1;
    p = '{8'h42, 8'h43};
    send_pkt(p, 1'b0);
    wait_out(3);
    rdy_mode = 0;
    exp_q = '{8'h41, 8'h42, 8'h43};
    vectors++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL echo_count: got %0d bytes, required 3", got_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL echo_byte[%0d]: got %02h, required %02h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_unknown_then_echo();
    bq_t p;
    got_q.delete();
    p = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h02, 8'h00,
          8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send_pkt(p, 1'b0);
    wait_out(1);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL unknown_echo: got %0d bytes first %02h, required 1 byte 5A",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_zero_payload();
    bq_t p;
    got_q.delete();
    p = '{8'hAD, 8'h00, 8'h04, 8'h00};
    send_pkt(p, 1'b0);
    @(negedge clk_i);
    vectors++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'h00) begin
      errors++;
      $display("FAIL zero_add_latency: m_valid=%b m_data=%02h, required 1 00", m_valid_o, m_data_o);
    end
    wait_out(4);
    vectors++;
    if (got_q.size() != 4 || got_q[0] !== 8'h00 || got_q[3] !== 8'h00) begin
      errors++;
      $display("FAIL zero_add: got %0d bytes, required 4 bytes of 00", got_q.size());
    end
  endtask

  task automatic test_mul();
    bq_t p;
    got_q.delete(); exp_q.delete();
    if (MUL_EN) exp_q = '{8'h0F, 8'h00, 8'h00, 8'h00};
    p = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt(p, 1'b0);
    wait_out(exp_q.size());
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mul_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mul_byte[%0d]: got %02h, required %02h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bq_t p;
    // Pending echo output stuck behind backpressure must be abandoned.
    rdy_mode = 3;
    @(posedge clk_i);
    #1;
    p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11};
    send_pkt(p, 1'b0);
    @(negedge clk_i);
    vectors++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'h11) begin
      errors++;
      $display("FAIL pending_echo: m_valid=%b m_data=%02h, required 1 11", m_valid_o, m_data_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset: s_ready=%b, required 0", s_ready_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rdy_mode = 0;
    @(negedge clk_i);
    vectors++;
    if (m_valid_o !== 1'b0 || m_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_abandon: m_valid=%b m_data=%02h, required 0 00", m_valid_o, m_data_o);
    end
    @(posedge clk_i);
    #1;
    got_q.delete();
    p = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00};
    send_pkt(p, 1'b0);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    p = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt(p, 1'b0);
    wait_out(4);
    exp_q = '{8'h07, 8'h00, 8'h00, 8'h00};
    vectors++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d bytes, required 4", got_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_byte[%0d]: got %02h, required %02h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bq_t p;
    int len;
    logic [7:0] op;
    got_q.delete(); exp_q.delete();
    rdy_mode = 2;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       op = 8'hEC;
        1:       op = 8'hAD;
        2:       op = 8'h88;
        default: op = 8'($urandom);
      endcase
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : 4 + int'($urandom_range(1, 14));
      p.delete();
      p.push_back(op);
      p.push_back(8'($urandom));
      p.push_back(len[7:0]);
      p.push_back(len[15:8]);
      for (int i = 4; i < len; i++) p.push_back(8'($urandom));
      model_append(p);
      send_pkt(p, 1'b1);
    end
    wait_out(exp_q.size());
    rdy_mode = 0;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_byte[%0d]: got %02h, required %02h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_echo_backpressure();
    test_unknown_then_echo();
    test_zero_payload();
    test_mul();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
